// File: rtl/sccb_arbiter_pkg.sv
// sccb_pkg: shared types and constants for the SCCB write arbiter.
//   state_t        - arbiter FSM states
//   COM7_ADDR      - OV7670 COM7 register address
//   COM7_RESET_BIT - COM7 bit that triggers a sensor soft reset
package sccb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    SETTLE    = 2'd3
  } state_t;

  localparam logic [7:0]  COM7_ADDR      = 8'h12;
  localparam int unsigned COM7_RESET_BIT = 7;

endpackage

// File: rtl/sccb_arbiter_if.sv
// sccb_arbiter_if: requester and SCCB-master signals around sccb_arbiter.
//   modport master : the arbiter (drives grants, dones, busy/owner, start/operands)
//   slave          : the surrounding requesters and SCCB master
// Signals:
//   i_Req0/1, i_Addr0/1, i_Data0/1  requester write requests and operands
//   o_Gnt0/1, o_Done0/1             one-cycle grant / completion pulses
//   o_Busy, o_Owner                 transaction in progress, current/last owner
//   i_SCCB_fReady                   master idle level
//   o_SCCB_fStart, o_SCCB_Address, o_SCCB_Value  start pulse and latched operands
interface sccb_arbiter_if;

  logic       i_Req0;
  logic       i_Req1;
  logic [7:0] i_Addr0;
  logic [7:0] i_Addr1;
  logic [7:0] i_Data0;
  logic [7:0] i_Data1;
  logic       o_Gnt0;
  logic       o_Gnt1;
  logic       o_Done0;
  logic       o_Done1;
  logic       o_Busy;
  logic       o_Owner;
  logic       i_SCCB_fReady;
  logic       o_SCCB_fStart;
  logic [7:0] o_SCCB_Address;
  logic [7:0] o_SCCB_Value;

  modport master (
    input  i_Req0, i_Req1, i_Addr0, i_Addr1, i_Data0, i_Data1, i_SCCB_fReady,
    output o_Gnt0, o_Gnt1, o_Done0, o_Done1, o_Busy, o_Owner,
           o_SCCB_fStart, o_SCCB_Address, o_SCCB_Value
  );

  modport slave (
    output i_Req0, i_Req1, i_Addr0, i_Addr1, i_Data0, i_Data1, i_SCCB_fReady,
    input  o_Gnt0, o_Gnt1, o_Done0, o_Done1, o_Busy, o_Owner,
           o_SCCB_fStart, o_SCCB_Address, o_SCCB_Value
  );

endinterface

// File: rtl/sccb_settle_timer.sv
// sccb_settle_timer: loadable CNT_W-bit down-counter for post-write settle time.
//   i_Clk, i_Rst (async, active-low) - clock / reset (reset clears the count)
//   i_Load, i_Load_Val               - load the counter (has priority over i_Dec)
//   i_Dec                            - decrement by one
//   o_Zero                           - count is zero
module sccb_settle_timer #(
  parameter int unsigned CNT_W = 15
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Load_Val,
  input  logic             i_Dec,
  output logic             o_Zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt <= '0;
    end else if (i_Load) begin
      cnt <= i_Load_Val;
    end else if (i_Dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign o_Zero = (cnt == '0);

endmodule

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: shares one SCCB master between two register-write requesters
// (0 = power-up init sequencer, 1 = runtime writer). Grants one request,
// latches its address/value, pulses the master start, tracks fReady for
// completion, then waits a settle time (longer after a COM7 soft reset)
// before pulsing done to the owner.
// Ports:
//   i_Clk  - clock
//   i_Rst  - asynchronous active-low reset
//   bus    - sccb_arbiter_if.master (requests, grants, dones, SCCB master link)
// Parameters: SETTLE_CYC, RESET_SETTLE_CYC, CNT_W (must hold the larger settle).
// Build option: define SCCB_ARB_RR_EN for round-robin tie-breaking; otherwise
// requester 0 has fixed priority.
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC       = 16,
  parameter int unsigned RESET_SETTLE_CYC = 25000,
  parameter int unsigned CNT_W            = 15
) (
  input logic            i_Clk,
  input logic            i_Rst,
  sccb_arbiter_if.master bus
);

  state_t           state;
  logic             any_req;
  logic             winner;
  logic             is_reset_wr;
  logic [CNT_W-1:0] settle_len;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;

  assign any_req = bus.i_Req0 | bus.i_Req1;

  always_comb begin
`ifdef SCCB_ARB_RR_EN
    if (bus.i_Req0 && bus.i_Req1) winner = ~bus.o_Owner;
    else                          winner = bus.i_Req1;
`else
    winner = ~bus.i_Req0;
`endif
  end

  assign is_reset_wr = (bus.o_SCCB_Address == COM7_ADDR) &&
                       bus.o_SCCB_Value[COM7_RESET_BIT];
  assign settle_len  = is_reset_wr ? CNT_W'(RESET_SETTLE_CYC) : CNT_W'(SETTLE_CYC);

  // The timer is loaded with len-1 and done fires on the edge that sees zero,
  // so done lands exactly len edges after the one that saw fReady return.
  // A zero length never enters SETTLE: done fires on the WAIT_DONE exit edge.
  assign tmr_load = (state == WAIT_DONE) && bus.i_SCCB_fReady && (settle_len != '0);
  assign tmr_dec  = (state == SETTLE) && !tmr_zero;

  sccb_settle_timer #(.CNT_W(CNT_W)) u_settle (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (tmr_load),
    .i_Load_Val (settle_len - CNT_W'(1)),
    .i_Dec      (tmr_dec),
    .o_Zero     (tmr_zero)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state              <= IDLE;
      bus.o_Gnt0         <= 1'b0;
      bus.o_Gnt1         <= 1'b0;
      bus.o_Done0        <= 1'b0;
      bus.o_Done1        <= 1'b0;
      bus.o_Busy         <= 1'b0;
      bus.o_Owner        <= 1'b0;
      bus.o_SCCB_fStart  <= 1'b0;
      bus.o_SCCB_Address <= '0;
      bus.o_SCCB_Value   <= '0;
    end else begin
      bus.o_Gnt0        <= 1'b0;
      bus.o_Gnt1        <= 1'b0;
      bus.o_Done0       <= 1'b0;
      bus.o_Done1       <= 1'b0;
      bus.o_SCCB_fStart <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req && bus.i_SCCB_fReady) begin
            bus.o_Gnt0         <= ~winner;
            bus.o_Gnt1         <= winner;
            bus.o_SCCB_fStart  <= 1'b1;
            bus.o_SCCB_Address <= winner ? bus.i_Addr1 : bus.i_Addr0;
            bus.o_SCCB_Value   <= winner ? bus.i_Data1 : bus.i_Data0;
            bus.o_Busy         <= 1'b1;
            bus.o_Owner        <= winner;
            state              <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.i_SCCB_fReady) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.i_SCCB_fReady) begin
            if (settle_len == '0) begin
              bus.o_Done0 <= ~bus.o_Owner;
              bus.o_Done1 <= bus.o_Owner;
              bus.o_Busy  <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            bus.o_Done0 <= ~bus.o_Owner;
            bus.o_Done1 <= bus.o_Owner;
            bus.o_Busy  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: directed, self-checking bench for sccb_arbiter.
// Expected transactions (owner, operands, settle length) are queued when a
// request is driven and compared when the DUT grants and completes. The
// bench plays the SCCB master by driving fReady by hand.
module tb_sccb_arbiter;

  localparam int unsigned SETTLE     = 16;
  localparam int unsigned RST_SETTLE = 25000;

  typedef struct {
    logic        owner;
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned settle;
  } exp_t;

  logic clk;
  logic rst_n;
  sccb_arbiter_if bus_if ();

  sccb_arbiter #(
    .SETTLE_CYC       (SETTLE),
    .RESET_SETTLE_CYC (RST_SETTLE),
    .CNT_W            (15)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus_if)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  logic        last_owner = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tie-break the bench expects when both requesters are held.
  function automatic logic tie_winner(input logic prev_owner);
`ifdef SCCB_ARB_RR_EN
    return ~prev_owner;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic owner, input logic [7:0] a, input logic [7:0] d,
                      input int unsigned settle);
    exp_t e;
    e.owner = owner; e.addr = a; e.data = d; e.settle = settle;
    exp_q.push_back(e);
  endtask

  task automatic grant_phase(input bit drop, output int unsigned lat);
    bit got;
    bit have;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (lat == 1)
        check("done_pulse_width", {30'd0, bus_if.o_Done0, bus_if.o_Done1}, 32'd0);
      got = bus_if.o_Gnt0 | bus_if.o_Gnt1;
    end
    check("gnt_seen", {31'd0, got}, 32'd1);
    have = (exp_q.size() != 0);
    check("sb_nonempty", {31'd0, have}, 32'd1);
    if (have) cur = exp_q.pop_front();
    if (got) begin
      check("gnt0",   {31'd0, bus_if.o_Gnt0},   {31'd0, ~cur.owner});
      check("gnt1",   {31'd0, bus_if.o_Gnt1},   {31'd0, cur.owner});
      check("fstart", {31'd0, bus_if.o_SCCB_fStart}, 32'd1);
      check("owner",  {31'd0, bus_if.o_Owner},  {31'd0, cur.owner});
      check("addr",   {24'd0, bus_if.o_SCCB_Address}, {24'd0, cur.addr});
      check("value",  {24'd0, bus_if.o_SCCB_Value},   {24'd0, cur.data});
      check("busy_at_gnt", {31'd0, bus_if.o_Busy}, 32'd1);
    end
    last_owner = cur.owner;
    if (drop) begin
      if (cur.owner) bus_if.i_Req1 = 1'b0;
      else           bus_if.i_Req0 = 1'b0;
    end
    // Master accepts the start: fReady drops the cycle after start.
    bus_if.i_SCCB_fReady = 1'b0;
  endtask

  task automatic finish_phase(input int unsigned busy_cyc);
    int unsigned n;
    bit got;
    repeat (busy_cyc) tick();
    check("pulses_cleared", {29'd0, bus_if.o_Gnt0, bus_if.o_Gnt1, bus_if.o_SCCB_fStart}, 32'd0);
    check("busy_in_xfer", {31'd0, bus_if.o_Busy}, 32'd1);
    bus_if.i_SCCB_fReady = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < cur.settle + 20) begin
      tick();
      n++;
      got = bus_if.o_Done0 | bus_if.o_Done1;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    // Tick 1 is the edge that first sees fReady high; done follows settle edges later.
    check("settle_ticks", n, cur.settle + 1);
    check("done0", {31'd0, bus_if.o_Done0}, {31'd0, ~cur.owner});
    check("done1", {31'd0, bus_if.o_Done1}, {31'd0, cur.owner});
    check("busy_at_done", {31'd0, bus_if.o_Busy}, 32'd0);
    check("addr_held",  {24'd0, bus_if.o_SCCB_Address}, {24'd0, cur.addr});
    check("value_held", {24'd0, bus_if.o_SCCB_Value},   {24'd0, cur.data});
  endtask

  initial begin
    int unsigned lat;
    logic        lw;
    logic        w;
    logic        seen;

    rst_n                = 1'b0;
    bus_if.i_Req0        = 1'b0;
    bus_if.i_Req1        = 1'b0;
    bus_if.i_Addr0       = '0;
    bus_if.i_Addr1       = '0;
    bus_if.i_Data0       = '0;
    bus_if.i_Data1       = '0;
    bus_if.i_SCCB_fReady = 1'b1;
    tick();
    tick();
    check("reset_outputs",
          {9'd0, bus_if.o_Gnt0, bus_if.o_Gnt1, bus_if.o_Done0, bus_if.o_Done1,
           bus_if.o_Busy, bus_if.o_Owner, bus_if.o_SCCB_fStart,
           bus_if.o_SCCB_Address, bus_if.o_SCCB_Value}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic write from requester 0, 20-cycle master busy.
    bus_if.i_Addr0 = 8'h11; bus_if.i_Data0 = 8'h01; bus_if.i_Req0 = 1'b1;
    push(1'b0, 8'h11, 8'h01, SETTLE);
    grant_phase(1'b1, lat);
    check("gnt_latency_basic", lat, 1);
    finish_phase(20);

    // COM7 soft reset: long settle.
    bus_if.i_Addr0 = 8'h12; bus_if.i_Data0 = 8'h80; bus_if.i_Req0 = 1'b1;
    push(1'b0, 8'h12, 8'h80, RST_SETTLE);
    grant_phase(1'b1, lat);
    finish_phase(5);

    // COM7 write without the reset bit: normal settle.
    bus_if.i_Addr0 = 8'h12; bus_if.i_Data0 = 8'h04; bus_if.i_Req0 = 1'b1;
    push(1'b0, 8'h12, 8'h04, SETTLE);
    grant_phase(1'b1, lat);
    finish_phase(3);

    // Requester 1 while the master is not ready: no grant until fReady.
    bus_if.i_SCCB_fReady = 1'b0;
    bus_if.i_Addr1 = 8'h3A; bus_if.i_Data1 = 8'h55; bus_if.i_Req1 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | bus_if.o_Gnt0 | bus_if.o_Gnt1 | bus_if.o_SCCB_fStart;
    end
    check("no_gnt_not_ready", {31'd0, seen}, 32'd0);
    bus_if.i_SCCB_fReady = 1'b1;
    push(1'b1, 8'h3A, 8'h55, SETTLE);
    grant_phase(1'b1, lat);
    check("gnt_latency_ready", lat, 1);
    finish_phase(4);

    // Both requesters held: three grants, then requester 0 drops.
    bus_if.i_Addr0 = 8'h20; bus_if.i_Data0 = 8'h01;
    bus_if.i_Addr1 = 8'h30; bus_if.i_Data1 = 8'h02;
    bus_if.i_Req0 = 1'b1; bus_if.i_Req1 = 1'b1;
    lw = last_owner;
    for (int unsigned i = 0; i < 3; i++) begin
      w = tie_winner(lw);
      push(w, w ? 8'h30 : 8'h20, w ? 8'h02 : 8'h01, SETTLE);
      lw = w;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      grant_phase(1'b0, lat);
      check("gnt_latency_tie", lat, 1);
      finish_phase(2);
    end
    bus_if.i_Req0 = 1'b0;
    push(1'b1, 8'h30, 8'h02, SETTLE);
    grant_phase(1'b1, lat);
    check("gnt_latency_req1", lat, 1);
    finish_phase(2);

    // Requester 1 raised and dropped while requester 0 is in flight.
    bus_if.i_Addr0 = 8'h3B; bus_if.i_Data0 = 8'h10; bus_if.i_Req0 = 1'b1;
    push(1'b0, 8'h3B, 8'h10, SETTLE);
    grant_phase(1'b1, lat);
    bus_if.i_Req1 = 1'b1;
    repeat (3) tick();
    bus_if.i_Req1 = 1'b0;
    finish_phase(10);
    seen = 1'b0;
    repeat (25) begin
      tick();
      seen = seen | bus_if.o_Gnt0 | bus_if.o_Gnt1;
    end
    check("no_gnt_dropped_req", {31'd0, seen}, 32'd0);

    // Reset during WAIT_DONE aborts the transfer with no done pulse.
    bus_if.i_Addr1 = 8'h40; bus_if.i_Data1 = 8'h33; bus_if.i_Req1 = 1'b1;
    push(1'b1, 8'h40, 8'h33, SETTLE);
    grant_phase(1'b1, lat);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {9'd0, bus_if.o_Gnt0, bus_if.o_Gnt1, bus_if.o_Done0, bus_if.o_Done1,
           bus_if.o_Busy, bus_if.o_Owner, bus_if.o_SCCB_fStart,
           bus_if.o_SCCB_Address, bus_if.o_SCCB_Value}, 32'd0);
    bus_if.i_SCCB_fReady = 1'b1;
    bus_if.i_Addr0 = 8'h21; bus_if.i_Data0 = 8'h5A; bus_if.i_Req0 = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | bus_if.o_Done0 | bus_if.o_Done1 | bus_if.o_Gnt0 | bus_if.o_Gnt1;
    end
    check("quiet_in_reset", {31'd0, seen}, 32'd0);
    rst_n = 1'b1;
    last_owner = 1'b0;
    push(1'b0, 8'h21, 8'h5A, SETTLE);
    grant_phase(1'b1, lat);
    check("gnt_latency_after_reset", lat, 1);
    finish_phase(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Shares the single SCCB master between two register-write requesters: requester 0 is the power-up camera init sequencer, requester 1 is the runtime register writer (exposure/gain/mode updates). The block arbitrates, latches one address/value pair, starts the master, and tracks the master's ready level to detect completion. It then enforces a post-write settle time, longer after an OV7670 soft reset, before reporting done. It sits between the requesters and the SCCB master.

## Interface
Parameters:
- SETTLE_CYC, 16: idle cycles after every completed write; 0 means no settle.
- RESET_SETTLE_CYC, 25000: settle cycles after a COM7 soft-reset write; 1 ms at 25 MHz.
- CNT_W, 15: settle counter width; must hold max(SETTLE_CYC, RESET_SETTLE_CYC).

Ports:
- i_Clk  in  1  single clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Req0 / i_Req1  in  1  write request level; held until grant.
- i_Addr0 / i_Addr1  in  8  register address; stable while request is high.
- i_Data0 / i_Data1  in  8  register value; stable while request is high.
- o_Gnt0 / o_Gnt1  out  1  one-cycle pulse: operands latched, request consumed.
- o_Done0 / o_Done1  out  1  one-cycle pulse: write plus settle complete.
- o_Busy  out  1  high from grant until done.
- o_Owner  out  1  index of the current or last granted requester.
- i_SCCB_fReady  in  1  master idle level.
- o_SCCB_fStart  out  1  one-cycle start pulse to the master.
- o_SCCB_Address  out  8  latched address.
- o_SCCB_Value  out  8  latched value.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE and clears the settle counter.
- IDLE: if any request is high and i_SCCB_fReady=1, the block selects a winner and goes to WAIT_BUSY. In that same clock edge it:
  - pulses o_GntN and o_SCCB_fStart,
  - latches the winner's address and value,
  - sets o_Busy and o_Owner.
- If i_SCCB_fReady=0, the block stays in IDLE and grants nothing.
- WAIT_BUSY: waits for i_SCCB_fReady=0, meaning the master accepted the start. No timeout.
- WAIT_DONE: waits for i_SCCB_fReady=1. Then it loads the settle counter:
  - RESET_SETTLE_CYC when the latched address is 8'h12 and value bit 7 is 1;
  - otherwise SETTLE_CYC.
- SETTLE: counts down to 0, then pulses o_DoneN for the owner, clears o_Busy and returns to IDLE. A load value of 0 skips SETTLE: done pulses on the cycle after WAIT_DONE exits.
- Requests arriving while busy are held, not queued. A request dropped before its grant is simply not served.
- Arbitration without the macro is fixed priority: requester 0 wins ties, and requester 1 may starve. This is intended, because init must finish first.
- Reset mid-transaction aborts all tracking and emits no done pulse. The master is reset on the same i_Rst.

## Timing
- Request sampled high in IDLE with fReady=1 → grant and start on the next edge: latency 1 cycle.
- Minimum request-to-done time, with SETTLE_CYC=0 and a master that drops fReady the cycle after start: 1 (grant) + 1 (WAIT_BUSY) + master busy time + 1 cycle.
- Done to next grant: at least 1 cycle; IDLE is always visited.
- o_SCCB_Address and o_SCCB_Value stay constant from grant until the next grant.

## Configuration
- SCCB_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester not equal to o_Owner wins.
- SCCB_ARB_RR_EN undefined: fixed priority, requester 0 first.
- The macro affects only winner selection; the state machine and timing are identical in both builds.

## Structure
- Package sccb_pkg holds:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE, SETTLE);
  - constant COM7_ADDR = 8'h12;
  - constant COM7_RESET_BIT = 7.
- One sub-module, sccb_settle_timer: a loadable CNT_W-bit down-counter with a load input, load value and a zero flag.

## Test plan
- Req0 with addr 8'h11 / data 8'h01, fReady=1, master busy 20 cycles → Gnt0 one cycle later with fStart in the same cycle; Done0 exactly 16 cycles after fReady returns high.
- Req0 with addr 8'h12 / data 8'h80 → settle of 25000 cycles before Done0. Data 8'h04 at the same address → 16-cycle settle.
- Req0 and Req1 asserted together and held, without the macro → grant sequence 0, 0, 0…, and Gnt1 only after Req0 drops. With SCCB_ARB_RR_EN → grants alternate 0, 1, 0, 1.
- Req1 asserted while fReady=0 → no grant until fReady=1, then grant 1 cycle later.
- i_Rst pulled low during WAIT_DONE → all outputs 0 at once and no Done pulse. After release with Req0 high → a fresh grant.
- Req1 dropped while the block is busy with requester 0 → no Gnt1 ever issued.
